// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array instruction sequencer:
// opcodes, FSM state encoding and datapath index widths.
package sa_pkg;

    localparam int COL_W  = 8;
    localparam int OUT_AW = 7;
    // Wide enough for the longest EXEC phase: 256 + 2*(11-1) + 1 cycles.
    localparam int CNT_W  = 10;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_STORE   = 4'd1;
    localparam logic [3:0] OP_COMPUTE = 4'd2;
    localparam logic [3:0] OP_CLEAR   = 4'd4;
    localparam logic [3:0] OP_HALT    = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sa_instr_sequencer_if.sv
// Sequencer-facing bundle: host start/done handshake, instruction fetch bus
// and the datapath control strobes.
interface sa_instr_sequencer_if #(
    parameter int IMEM_AW = 3
);
    import sa_pkg::*;

    logic               ap_start;
    logic               ap_done;
    logic               busy;
    logic [IMEM_AW-1:0] imem_addr;
    logic [3:0]         imem_data;
    logic [3:0]         curr_instr;
    logic               mem_rd_en;
    logic [COL_W-1:0]   mem_col;
    logic               pe_en;
    logic               pe_clr;
    logic               out_we;
    logic [OUT_AW-1:0]  out_addr;

    modport master (
        input  ap_start, imem_data,
        output ap_done, busy, imem_addr, curr_instr,
               mem_rd_en, mem_col, pe_en, pe_clr, out_we, out_addr
    );

    modport slave (
        output ap_start, imem_data,
        input  ap_done, busy, imem_addr, curr_instr,
               mem_rd_en, mem_col, pe_en, pe_clr, out_we, out_addr
    );

endinterface

// File: rtl/sa_exec_counter.sv
// Loadable down-counter timing one EXEC phase; idx counts up from 0 alongside
// and done flags the final cycle of the phase.
module sa_exec_counter
    import sa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] idx,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (load) begin
            cnt_d = load_val;
            idx_d = '0;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            idx_d = idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign done = (cnt_q == '0);

endmodule

// File: rtl/sa_instr_sequencer.sv
// Program sequencer: fetches opcodes from instruction memory and drives the
// systolic-array datapath strobes, all of which leave this block registered.
module sa_instr_sequencer
    import sa_pkg::*;
#(
    parameter int N          = 4,
    parameter int K_LEN      = 21,
    parameter int IMEM_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_instr_sequencer_if.master bus
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam logic [CNT_W-1:0]   COMPUTE_LAST = CNT_W'(K_LEN + 2 * (N - 1));
    localparam logic [CNT_W-1:0]   STORE_LAST   = CNT_W'(N * N - 1);
    localparam logic [CNT_W-1:0]   K_LEN_C      = CNT_W'(K_LEN);
    localparam logic [IMEM_AW-1:0] PC_LAST      = IMEM_AW'(IMEM_DEPTH - 1);

    // Counter load value is the index of the last EXEC cycle (length - 1).
    function automatic logic [CNT_W-1:0] exec_last(input logic [3:0] op);
        case (op)
            OP_COMPUTE: exec_last = COMPUTE_LAST;
            OP_STORE:   exec_last = STORE_LAST;
            default:    exec_last = '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [IMEM_AW-1:0]  pc_q, pc_d;
    logic [3:0]          curr_instr_q, curr_instr_d;
    logic                pe_clr_q, pe_clr_d;
    logic                pe_en_q, pe_en_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [COL_W-1:0]    mem_col_q, mem_col_d;
    logic                out_we_q, out_we_d;
    logic [OUT_AW-1:0]   out_addr_q, out_addr_d;
    logic                ap_done_q, ap_done_d;
    logic                busy_q, busy_d;

    logic                cnt_load, cnt_en, cnt_done;
    logic [CNT_W-1:0]    cnt_load_val, cnt_idx;
    logic                issue;
    logic [3:0]          op_sel;
    logic [CNT_W-1:0]    t_sel;

    sa_exec_counter u_exec_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .idx      (cnt_idx),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        curr_instr_d = curr_instr_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        issue        = 1'b0;
        op_sel       = OP_NOP;
        t_sel        = '0;
        pe_clr_d     = 1'b0;
        pe_en_d      = 1'b0;
        mem_rd_en_d  = 1'b0;
        mem_col_d    = '0;
        out_we_d     = 1'b0;
        out_addr_d   = '0;

        // Strobes are computed one cycle ahead for the EXEC cycle index t_sel.
        case (state_q)
            ST_IDLE: begin
                if (bus.ap_start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                curr_instr_d = bus.imem_data;
                cnt_load     = 1'b1;
                cnt_load_val = exec_last(bus.imem_data);
                issue        = 1'b1;
                op_sel       = bus.imem_data;
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                if (!cnt_done) begin
                    cnt_en = 1'b1;
                    issue  = 1'b1;
                    op_sel = curr_instr_q;
                    t_sel  = cnt_idx + CNT_W'(1);
                end else if ((curr_instr_q == OP_HALT) || (pc_q == PC_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + IMEM_AW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            pe_clr_d    = (op_sel == OP_CLEAR);
            pe_en_d     = (op_sel == OP_COMPUTE);
            mem_rd_en_d = (op_sel == OP_COMPUTE) && (t_sel < K_LEN_C);
            mem_col_d   = mem_rd_en_d ? COL_W'(t_sel) : '0;
            out_we_d    = (op_sel == OP_STORE);
            out_addr_d  = out_we_d ? OUT_AW'(t_sel) : '0;
        end

        busy_d    = (state_d != ST_IDLE);
        ap_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            curr_instr_q <= '0;
            pe_clr_q     <= 1'b0;
            pe_en_q      <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_col_q    <= '0;
            out_we_q     <= 1'b0;
            out_addr_q   <= '0;
            ap_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            curr_instr_q <= curr_instr_d;
            pe_clr_q     <= pe_clr_d;
            pe_en_q      <= pe_en_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_col_q    <= mem_col_d;
            out_we_q     <= out_we_d;
            out_addr_q   <= out_addr_d;
            ap_done_q    <= ap_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.curr_instr = curr_instr_q;
    assign bus.pe_clr     = pe_clr_q;
    assign bus.pe_en      = pe_en_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_col    = mem_col_q;
    assign bus.out_we     = out_we_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.ap_done    = ap_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sa_instr_sequencer.sv
// Scoreboard bench for sa_instr_sequencer: a program-level model queues the
// expected strobe/fetch/done events per run and a monitor retires them.
module tb_sa_instr_sequencer;
    import sa_pkg::*;

    localparam int N     = 4;
    localparam int K_LEN = 21;
    localparam int DEPTH = 8;
    localparam int MAXC  = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_instr_sequencer_if #(.IMEM_AW(3)) bus ();

    sa_instr_sequencer #(.N(N), .K_LEN(K_LEN), .IMEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] imem [DEPTH];
    always @(posedge clk) bus.imem_data <= imem[bus.imem_addr];

    typedef struct {
        int cyc;
        bit done, clr, en, rd, we;
        int col, addr, instr;
    } ev_t;
    typedef struct {
        int cyc;
        int addr;
    } fe_t;

    ev_t sq[$];
    fe_t fq[$];
    bit  exp_busy [0:MAXC-1];

    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int c_clr, c_en, c_rd, c_we, c_done;
    int done_at, instr_at_done;
    int idle_from = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour of one program run whose ap_start is sampled in cycle L.
    task automatic model_run(input int L, output int D);
        int t, len, op, last;
        ev_t e;
        t = L + 1;
        last = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op = int'(imem[i]);
            fq.push_back('{cyc: t, addr: i});
            if (op == 2)      len = K_LEN + 2 * (N - 1) + 1;
            else if (op == 1) len = N * N;
            else              len = 1;
            for (int k = 0; k < len; k++) begin
                e = '{default: 0};
                e.cyc = t + 2 + k;
                e.instr = op;
                if (op == 4) e.clr = 1'b1;
                if (op == 2) begin
                    e.en = 1'b1;
                    e.rd = (k < K_LEN);
                    e.col = e.rd ? k : 0;
                end
                if (op == 1) begin
                    e.we = 1'b1;
                    e.addr = k;
                end
                if (e.clr || e.en || e.we) sq.push_back(e);
            end
            t += 2 + len;
            last = op;
            if (op == 15) break;
        end
        D = t;
        e = '{default: 0};
        e.cyc = D;
        e.done = 1'b1;
        e.instr = last;
        sq.push_back(e);
        for (int c = L + 1; c <= D; c++) exp_busy[c] = 1'b1;
        idle_from = D + 1;
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event: got none, expected event at cycle %0d (now %0d)", sq[0].cyc, cyc);
            void'(sq.pop_front());
        end
        while (fq.size() > 0 && fq[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_fetch: got none, expected fetch at cycle %0d", fq[0].cyc);
            void'(fq.pop_front());
        end
        if (bus.ap_done || bus.pe_clr || bus.pe_en || bus.mem_rd_en || bus.out_we) begin
            if (bus.pe_clr)    c_clr++;
            if (bus.pe_en)     c_en++;
            if (bus.mem_rd_en) c_rd++;
            if (bus.out_we)    c_we++;
            if (bus.ap_done) begin
                c_done++;
                done_at = cyc;
                instr_at_done = int'(bus.curr_instr);
            end
            if (sq.size() == 0 || sq[0].cyc != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got done=%0b clr=%0b en=%0b rd=%0b we=%0b at cycle %0d, expected no strobe",
                         bus.ap_done, bus.pe_clr, bus.pe_en, bus.mem_rd_en, bus.out_we, cyc);
            end else begin
                e = sq.pop_front();
                check("ap_done",    int'(bus.ap_done),    int'(e.done));
                check("pe_clr",     int'(bus.pe_clr),     int'(e.clr));
                check("pe_en",      int'(bus.pe_en),      int'(e.en));
                check("mem_rd_en",  int'(bus.mem_rd_en),  int'(e.rd));
                check("mem_col",    int'(bus.mem_col),    e.col);
                check("out_we",     int'(bus.out_we),     int'(e.we));
                check("out_addr",   int'(bus.out_addr),   e.addr);
                check("curr_instr", int'(bus.curr_instr), e.instr);
            end
        end
        if (fq.size() > 0 && fq[0].cyc == cyc) begin
            check("imem_addr", int'(bus.imem_addr), fq[0].addr);
            void'(fq.pop_front());
        end
        check("busy", int'(bus.busy), int'(exp_busy[cyc]));
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic launch(input logic [31:0] prog, output int L, output int D);
        @(negedge clk);
        wait_until(idle_from);
        for (int i = 0; i < DEPTH; i++) imem[i] = prog[4*i +: 4];
        c_clr = 0; c_en = 0; c_rd = 0; c_we = 0; c_done = 0;
        done_at = -1;
        instr_at_done = -1;
        @(negedge clk);
        bus.ap_start = 1'b1;
        L = cyc;
        model_run(L, D);
        @(negedge clk);
        bus.ap_start = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pe_clr_count"}, c_clr, 1);
        check({tag, "_pe_en_count"},  c_en, 28);
        check({tag, "_rd_count"},     c_rd, 21);
        check({tag, "_we_count"},     c_we, 16);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, int'({bus.ap_done, bus.busy, bus.mem_rd_en, bus.mem_col, bus.pe_en,
                                       bus.pe_clr, bus.out_we, bus.out_addr, bus.curr_instr, bus.imem_addr}), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    localparam logic [31:0] PROG_MAIN = 32'h0000_1204;
    localparam logic [31:0] PROG_HALT = 32'h4444_44F2;
    localparam logic [31:0] PROG_ILL  = 32'h7777_7777;

    initial begin : stim
        int L, D, D2;
        logic [3:0] pick [6];
        logic [31:0] rp;

        rst = 1'b1;
        bus.ap_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) imem[i] = 4'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_from = cyc + 1;

        launch(PROG_MAIN, L, D);
        wait_until(D + 2);
        check("main_done_cycle", done_at - L, 67);
        check("main_done_pulses", c_done, 1);
        check_counts("main");

        launch(PROG_HALT, L, D);
        wait_until(D + 2);
        check("halt_done_cycle", done_at - L, 34);
        check("halt_pe_clr_count", c_clr, 0);
        check("halt_instr_at_done", instr_at_done, 15);

        launch(PROG_ILL, L, D);
        wait_until(D + 2);
        check("illegal_done_cycle", done_at - L, 25);
        check("illegal_strobe_count", c_clr + c_en + c_rd + c_we, 0);

        // Asynchronous reset in the middle of the COMPUTE phase.
        launch(PROG_MAIN, L, D);
        wait_until(L + 19);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        sq.delete();
        fq.delete();
        for (int c = cyc; c < MAXC; c++) exp_busy[c] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_from = cyc + 1;
        launch(PROG_MAIN, L, D);
        wait_until(D + 2);
        check("rerun_done_cycle", done_at - L, 67);
        check_counts("rerun");

        // Mid-run pulse is ignored; level held across DONE relaunches once.
        launch(PROG_MAIN, L, D);
        wait_until(L + 10);
        bus.ap_start = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        wait_until(D - 2);
        bus.ap_start = 1'b1;
        wait_until(D + 1);
        model_run(D + 1, D2);
        wait_until(D + 4);
        bus.ap_start = 1'b0;
        wait_until(D2 + 3);
        check("hold_done_pulses", c_done, 2);
        check("hold_second_done_cycle", done_at - (D + 1), 67);

        pick[0] = OP_NOP; pick[1] = OP_STORE; pick[2] = OP_COMPUTE;
        pick[3] = OP_CLEAR; pick[4] = OP_HALT; pick[5] = 4'd0;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                pick[5] = 4'($urandom_range(0, 15));
                rp[4*i +: 4] = ($urandom_range(0, 9) == 0) ? OP_HALT : pick[$urandom_range(0, 5) % 6];
            end
            launch(rp, L, D);
            wait_until(L + 2);
            bus.ap_start = 1'b1;
            @(negedge clk);
            bus.ap_start = 1'b0;
            wait_until(D + 1 + int'($urandom_range(0, 3)));
        end

        wait_until(idle_from + 3);
        check("leftover_events", sq.size(), 0);
        check("leftover_fetches", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
